// File: rtl/keypad_pkg.sv
// Shared encodings for the 4x4 keypad scanner: FSM states, scan results and matrix size.
package keypad_pkg;

    localparam int COLS = 4;
    localparam int ROWS = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_DEB   = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_ONE   = 2'd1,
        RES_MULTI = 2'd2
    } scan_res_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// Column slot timer, one-hot active-low column rotation and 2-FF row synchroniser.
module keypad_col_driver
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [1:0] col_idx,
    output logic [3:0] rows_sync,
    output logic       sample_strobe,
    output logic       scan_done
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

    logic [SW-1:0] slot_cnt;
    logic [3:0]    row_meta;

    assign sample_strobe = (slot_cnt == SLOT_LAST);
    assign scan_done     = sample_strobe && (col_idx == 2'(COLS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt  <= '0;
            col_idx   <= 2'd0;
            col_n     <= 4'b1110;
            row_meta  <= 4'hF;
            rows_sync <= 4'hF;
        end else begin
            row_meta  <= row_n;
            rows_sync <= row_meta;
            if (sample_strobe) begin
                slot_cnt <= '0;
                col_idx  <= col_idx + 2'd1;
                col_n    <= {col_n[2:0], col_n[3]};
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_4x4_scanner.sv
// 4x4 keypad scanner: per-scan result encoding, debounce FSM and valid/ack key handoff.
// Define KEYPAD_REPEAT_EN to add auto-repeat of a held key every REPEAT_SCANS scans.
//
// state        | meaning
// ST_IDLE      | no key accepted, waiting for a single closed contact
// ST_PRESS_DEB | counting identical ONE(cand) scans towards acceptance
// ST_HELD      | key accepted and still closed
// ST_REL_DEB   | counting empty scans towards release
module keypad_4x4_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    input  logic       key_ack,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       overrun
);

    localparam int DW = $clog2(DEBOUNCE_SCANS) + 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_SCANS - 1);

    logic [1:0] col_idx;
    logic [3:0] rows_sync;
    logic       sample_strobe;
    logic       scan_done;

    keypad_col_driver #(.SCAN_DIV(SCAN_DIV)) u_col_driver (
        .clk           (clk),
        .reset         (reset),
        .row_n         (row_n),
        .col_n         (col_n),
        .col_idx       (col_idx),
        .rows_sync     (rows_sync),
        .sample_strobe (sample_strobe),
        .scan_done     (scan_done)
    );

    // acc_n saturates at 2: anything beyond one contact is already MULTI.
    logic [1:0] acc_n;
    logic [3:0] acc_key;
    logic [3:0] closed;
    logic [2:0] cur_n;
    logic [2:0] tot;
    logic [1:0] cur_row;
    logic [1:0] new_n;
    logic [3:0] new_key;
    scan_res_t  scan_res;

    always_comb begin
        closed  = ~rows_sync;
        cur_n   = popcount4(closed);
        cur_row = 2'd0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (closed[r]) cur_row = 2'(r);
        end
        tot      = {1'b0, acc_n} + cur_n;
        new_n    = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        new_key  = (acc_n == 2'd0) ? {cur_row, col_idx} : acc_key;
        case (new_n)
            2'd0:    scan_res = RES_NONE;
            2'd1:    scan_res = RES_ONE;
            default: scan_res = RES_MULTI;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_n   <= 2'd0;
            acc_key <= 4'd0;
        end else if (sample_strobe) begin
            acc_n   <= scan_done ? 2'd0 : new_n;
            acc_key <= new_key;
        end
    end

    kp_state_t      state;
    logic [3:0]     cand;
    logic [DW-1:0]  deb_cnt;
    logic           accept_p;
    logic           hit_cand;

    assign hit_cand = (scan_res == RES_ONE) && (new_key == cand);

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS) + 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);
    logic [RW-1:0] rep_cnt;
`else
    if (REPEAT_SCANS < 1) begin : g_repeat_range
        $error("REPEAT_SCANS must be >= 1");
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cand     <= 4'd0;
            deb_cnt  <= '0;
            accept_p <= 1'b0;
            key_down <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt  <= '0;
`endif
        end else begin
            accept_p <= 1'b0;
            if (scan_done) begin
                case (state)
                    ST_IDLE: begin
                        if (scan_res == RES_ONE) begin
                            cand    <= new_key;
                            deb_cnt <= DW'(1);
                            if (DEB_LAST == '0) begin
                                accept_p <= 1'b1;
                                key_down <= 1'b1;
                                state    <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt  <= '0;
`endif
                            end else begin
                                state <= ST_PRESS_DEB;
                            end
                        end
                    end
                    ST_PRESS_DEB: begin
                        if (hit_cand) begin
                            deb_cnt <= deb_cnt + DW'(1);
                            if (deb_cnt == DEB_LAST) begin
                                accept_p <= 1'b1;
                                key_down <= 1'b1;
                                state    <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt  <= '0;
`endif
                            end
                        end else begin
                            deb_cnt <= '0;
                            state   <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        if (hit_cand) begin
`ifdef KEYPAD_REPEAT_EN
                            if (rep_cnt == REP_LAST) begin
                                accept_p <= 1'b1;
                                rep_cnt  <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + RW'(1);
                            end
`endif
                        end else begin
                            deb_cnt <= DW'(1);
                            state   <= ST_REL_DEB;
                        end
                    end
                    default: begin
                        if (scan_res == RES_NONE) begin
                            if (deb_cnt >= DEB_LAST) begin
                                deb_cnt  <= '0;
                                key_down <= 1'b0;
                                state    <= ST_IDLE;
                            end else begin
                                deb_cnt <= deb_cnt + DW'(1);
                            end
                        end else if (hit_cand) begin
                            state <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt <= '0;
`endif
                        end else begin
                            deb_cnt <= DW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // An ack landing with a new accept consumes the old key, so overrun stays clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (accept_p) begin
            key_code  <= cand;
            key_valid <= 1'b1;
            if (key_valid && key_ack) overrun <= 1'b0;
            else if (key_valid)       overrun <= 1'b1;
        end else if (key_ack && key_valid) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_4x4_scanner.sv
// Scan-level reference bench for keypad_4x4_scanner: per-scan key masks, random plus directed.
module tb_keypad_4x4_scanner;

    localparam int SCAN_DIV  = 4;
    localparam int DEB       = 2;
    localparam int REP       = 3;
    localparam int SCAN_CYC  = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_n;
    logic       key_ack;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       overrun;
    logic [15:0] keys;

    int n_cmp = 0;
    int n_err = 0;

    keypad_4x4_scanner #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(REP)
    ) dut (
        .clk(clk), .reset(reset), .row_n(row_n), .key_ack(key_ack),
        .col_n(col_n), .key_code(key_code), .key_valid(key_valid),
        .key_down(key_down), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Key i sits at row i/4, column i%4 and pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col_n[c] && keys[r * 4 + c]) row_n[r] = 1'b0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model at whole-scan granularity.
    int m_mode;   // 0 idle, 1 counting press, 2 held, 3 counting release
    int m_cand, m_cnt, m_rep, m_code;
    bit m_valid, m_ovr;

    function automatic int scan_of(input logic [15:0] m);
        int n = $countones(m);
        if (n == 0) return -1;
        if (n > 1)  return -2;
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_accept();
        if (m_valid) m_ovr = 1'b1;
        m_code  = m_cand;
        m_valid = 1'b1;
    endtask

    task automatic model_scan(input int r);
        case (m_mode)
            0: if (r >= 0) begin
                m_cand = r; m_cnt = 1;
                if (DEB == 1) begin model_accept(); m_mode = 2; m_rep = 0; end
                else m_mode = 1;
            end
            1: if (r == m_cand) begin
                m_cnt++;
                if (m_cnt == DEB) begin model_accept(); m_mode = 2; m_rep = 0; end
            end else begin
                m_mode = 0; m_cnt = 0;
            end
            2: if (r == m_cand) begin
`ifdef KEYPAD_REPEAT_EN
                m_rep++;
                if (m_rep == REP) begin model_accept(); m_rep = 0; end
`endif
            end else begin
                m_cnt = 1; m_mode = 3;
            end
            default: if (r == -1) begin
                m_cnt++;
                if (m_cnt >= DEB) m_mode = 0;
            end else if (r == m_cand) begin
                m_mode = 2; m_rep = 0;
            end else begin
                m_cnt = 1;
            end
        endcase
    endtask

    logic [15:0] mask_q[$];
    bit          ack_q[$];

    task automatic push(input logic [15:0] m, input int n, input bit ack);
        for (int i = 0; i < n; i++) begin
            mask_q.push_back(m);
            ack_q.push_back(ack);
        end
    endtask

    task automatic check_outputs(input string where);
        check_eq({where, ".valid"},   key_valid, m_valid);
        check_eq({where, ".code"},    key_code,  m_code);
        check_eq({where, ".down"},    key_down,  (m_mode == 2 || m_mode == 3));
        check_eq({where, ".overrun"}, overrun,   m_ovr);
        check_eq({where, ".col0"},    col_n,     4'b1110);
    endtask

    initial begin
        logic [3:0]  exp_col;
        logic [15:0] m;
        int kind, len;

        m_mode = 0; m_cand = 0; m_cnt = 0; m_rep = 0; m_code = 0;
        m_valid = 1'b0; m_ovr = 1'b0;
        reset = 1'b0; key_ack = 1'b0; keys = 16'h0;

        repeat (3) @(negedge clk);
        check_eq("rst.col_n", col_n, 4'b1110);
        check_eq("rst.code", key_code, 0);
        check_eq("rst.valid", key_valid, 0);
        check_eq("rst.down", key_down, 0);
        check_eq("rst.overrun", overrun, 0);

        reset = 1'b1;
        for (int n = 1; n <= SCAN_CYC; n++) begin
            @(negedge clk);
            exp_col = 4'hF ^ (4'b0001 << ((n / SCAN_DIV) % 4));
            check_eq("col_step", col_n, exp_col);
        end
        model_scan(-1);
        @(negedge clk);

        // Directed: clean press of 9 with ack, bounce, chord, overrun.
        push(16'h0, 1, 0);
        push(16'h1 << 9, 2, 0);
        push(16'h1 << 9, 1, 1);
        push(16'h1 << 9, 1, 0);
        push(16'h0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            push(16'h1 << 5, 1, 0);
            push(16'h0, 1, 0);
        end
        push(16'h0009, 4, 0);
        push(16'h0, 2, 0);
        push(16'h1 << 7, 3, 0);
        push(16'h0, 3, 0);
        push(16'h1 << 2, 3, 0);
        push(16'h0, 1, 1);
        push(16'h0, 2, 0);
`ifdef KEYPAD_REPEAT_EN
        push(16'h1 << 12, 10, 1);
        push(16'h0, 3, 1);
`endif
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            len  = $urandom_range(1, 4);
            case (kind)
                0: m = 16'h0;
                4: m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                5: m = 16'(1 << $urandom_range(0, 15));
                default: m = 16'(1 << $urandom_range(0, 15));
            endcase
            if (kind == 5) begin
                for (int j = 0; j < len; j++) begin
                    push(m, 1, $urandom_range(0, 2) == 0);
                    push(16'h0, 1, 0);
                end
            end else begin
                for (int j = 0; j < len; j++) push(m, 1, $urandom_range(0, 2) == 0);
            end
        end
        push(16'h0, 3, 0);
        push(16'h1 << 6, 3, 0);

        while (mask_q.size() > 0) begin
            bit ack;
            m   = mask_q.pop_front();
            ack = ack_q.pop_front();
            check_outputs("scan");
            keys = m;
            if (ack) begin
                key_ack = 1'b1;
                @(negedge clk);
                key_ack = 1'b0;
                if (m_valid) begin m_valid = 1'b0; m_ovr = 1'b0; end
                check_eq("ack.valid", key_valid, m_valid);
                check_eq("ack.overrun", overrun, m_ovr);
                repeat (SCAN_CYC - 1) @(posedge clk);
            end else begin
                repeat (SCAN_CYC) @(posedge clk);
            end
            @(negedge clk);
            model_scan(scan_of(m));
        end
        check_outputs("last");

        // Asynchronous reset with key 6 still held: state discarded, key re-debounced.
        reset = 1'b0;
        #1;
        check_eq("midrst.valid", key_valid, 0);
        check_eq("midrst.down", key_down, 0);
        check_eq("midrst.col_n", col_n, 4'b1110);
        @(negedge clk);
        reset = 1'b1;
        repeat (DEB * SCAN_CYC) @(posedge clk);
        @(negedge clk);
        check_eq("latency.before", key_valid, 0);
        @(negedge clk);
        check_eq("latency.valid", key_valid, 1);
        check_eq("latency.code", key_code, 6);
        check_eq("latency.down", key_down, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_4x4_scanner.md
Name: keypad_4x4_scanner

Overview:
- Input-side counterpart of the seg7x16 display scanner: scans a 4x4 matrix keypad instead of driving multiplexed digits.
- Drives one column low at a time, samples the four row lines, debounces the result over whole scans and presents a single key code to the CPU side.
- Key handoff uses a valid/ack handshake.
- Sits in the board top level beside the display scanner, on the undivided board clock.

Parameters:
- SCAN_DIV, 1000: clock cycles per column slot (SCAN_DIV >= 4).
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press or a release (>= 1).
- REPEAT_SCANS, 50: scans between auto-repeat events while a key is held (used only with the optional feature).

Ports:
- clk  in  1  board clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- row_n  in  4  keypad row lines, pulled up; 0 = key closed in the driven column.
- key_ack  in  1  consumer acknowledge, one-cycle pulse.
- col_n  out  4  column drive, one-hot active-low.
- key_code  out  4  accepted key, code = row*4 + col.
- key_valid  out  1  key_code holds an unconsumed key.
- key_down  out  1  debounced "a key is held".
- overrun  out  1  sticky: a key was accepted while key_valid was already 1.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - col_n=4'b1110, key_code=0, key_valid=0, key_down=0, overrun=0.
  - Slot counter=0, column index=0, FSM=IDLE, debounce counter=0.
- Reset release: scanning starts at column 0 on the first clock after reset goes high.
- Row synchronisation: row_n passes through a 2-FF synchroniser, so the sampled value lags the pins by 2 cycles.
- Column slots:
  - Each column is driven for exactly SCAN_DIV cycles.
  - The synchronised rows are sampled on the last cycle of the slot.
  - The column index then advances 0->1->2->3->0, and col_n rotates at the same edge.
- Scan result: formed at the end of the column-3 slot as one of:
  - NONE: zero closed contacts.
  - ONE(K): exactly one closed contact, K = row*4 + col.
  - MULTI: two or more closed contacts (ghosting/chording).
- FSM, evaluated once per scan result:
  - IDLE: ONE(K) -> cand=K, cnt=1; if DEBOUNCE_SCANS==1, accept immediately, else go to PRESS_DEB. NONE or MULTI -> stay.
  - PRESS_DEB: ONE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS, accept and go to HELD. Anything else -> IDLE, cnt=0.
  - HELD: ONE(cand) -> stay. Anything else -> cnt=1, go to REL_DEB.
  - REL_DEB: NONE -> cnt+1; at DEBOUNCE_SCANS go to IDLE. ONE(cand) -> HELD. ONE(other) or MULTI -> stay, cnt=1.
- key_down = 1 in HELD and REL_DEB.
- Accept, registered, one cycle after the scan-result evaluation:
  - key_code <= cand, key_valid <= 1.
  - If key_valid=1 and key_ack=0 in that cycle, set overrun=1; the new code still overwrites.
- Handshake:
  - key_ack while key_valid=1: key_valid=0 and overrun=0 next cycle.
  - key_ack while key_valid=0: ignored.
- Accept and ack in the same cycle: new key loaded, key_valid stays 1, overrun not set.
- Counter widths: $clog2 of the parameter, plus 1 where needed; no wrap is possible within any state.
- Latency, clean press from an IDLE scan boundary: DEBOUNCE_SCANS*4*SCAN_DIV cycles + 1 to key_valid.
- Asynchronous reset mid-scan or mid-debounce discards all state; a held key is re-debounced from IDLE.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter increments per ONE(cand) scan.
  - When it reaches REPEAT_SCANS it re-accepts cand (same accept/overrun rules) and clears.
  - The counter clears on entry to HELD.
- Undefined: no repeat logic is synthesised; one key event per press.

Decomposition:
- Package keypad_pkg holds:
  - FSM state encoding (IDLE, PRESS_DEB, HELD, REL_DEB).
  - Scan-result encoding (NONE, ONE, MULTI).
  - Constant COLS=4, ROWS=4.
- One sub-module, keypad_col_driver:
  - Contains the slot counter, column index, col_n rotation and the 2-FF row synchroniser.
  - Outputs sample_strobe, col_idx, rows_sync and scan_done.
- The FSM, result encoder and handshake live in the top.

Test Plan:
- Reset check (SCAN_DIV=4, DEBOUNCE_SCANS=2):
  - Hold reset=0 -> col_n=1110, all outputs 0.
  - Release -> col_n steps 1110, 1101, 1011, 0111, every 4 cycles.
- Clean press of key 9 (row 2, col 1; pull row_n[2] low whenever col_n[1]=0):
  - key_code=9, key_valid=1 after 2 full scans (+1 cycle); key_down=1.
  - key_ack -> key_valid=0 next cycle.
- Bounce: key 5 present for 1 scan, absent 1 scan, repeated -> key_valid never rises.
- Chord: keys 0 and 3 pressed together -> MULTI, no acceptance.
- Release then press key 2 with no ack of the first key 7 -> key_code=2, overrun=1; ack -> both valid and overrun cleared.
- With KEYPAD_REPEAT_EN, REPEAT_SCANS=3, key 12 held 10 scans, ack each event -> one initial accept plus one repeat every 3 held scans, all with key_code=12.
